alu32_result_queue: RTL and testbench
=====================================

# alu32_result_queue

Downstream companion to the `alu32` stage. It tracks operations issued to the ALU, captures each registered ALU result one cycle after issue, and tags it with the opcode and zero/negative flags. Results are buffered in a small in-order FIFO and presented to the consumer over a valid/ready handshake. An issue-side credit signal throttles the issuer so that no result is ever dropped.

## Interface
- `DEPTH`, 4: result FIFO entries; power of two, ≥ 2.
- `W`, 32: datapath width; must match the ALU.
- `CW`, $clog2(DEPTH)+1: width of `count`, derived.
- `clk` in 1: the single clock; rising-edge, shared with `alu32`.
- `rst` in 1: reset, asynchronous and active-high.
- `issue_valid` in 1: issuer presents `a`/`b`/`sel` to the ALU this cycle.
- `issue_sel` in 4: the same `sel` value being driven to the ALU.
- `issue_ready` out 1: the issuer may issue. The ALU samples operands only when `issue_valid && issue_ready`; the issuer gates its drive accordingly.
- `alu_out` in W: the ALU `out` register.
- `res_valid` out 1: head FIFO entry is valid.
- `res_data` out W: head result.
- `res_sel` out 4: opcode of the head result.
- `res_zero` out 1: head result == 0.
- `res_neg` out 1: head result bit W-1.
- `res_ready` in 1: consumer accepts the head entry.
- `count` out CW: current FIFO occupancy, 0..DEPTH.

## Operation
- **Accept.** `acc = issue_valid && issue_ready`. On an `acc` edge: `inflight <= 1` and `inflight_sel <= issue_sel`. On a non-accept edge: `inflight <= 0`.
- **Capture.**
  - In the cycle after an accept, `alu_out` holds that operation's result.
  - On the next edge, if `inflight == 1`, push `{alu_out, inflight_sel, alu_out == 0, alu_out[W-1]}` at `wr_ptr`.
  - `alu_out` is ignored whenever `inflight == 0`.
- **Credit.** `issue_ready = !rst && (count + inflight < DEPTH)`. This is purely combinational from registered state. No credit is taken for a same-cycle pop; this is intentionally conservative.
- **FIFO.**
  - `wr_ptr` and `rd_ptr` are log2(DEPTH)+1 bits wide. Addresses use the low bits, so wrap-around is natural.
  - Show-ahead: the `res_*` outputs read the array at `rd_ptr` combinationally.
  - `res_valid = (count != 0)`.
  - Pop on `res_valid && res_ready`; `rd_ptr` increments.
- **Simultaneous push and pop:** both pointers advance and `count` is unchanged. This is legal at any occupancy from 1 to DEPTH-1.
- **Push when full** cannot occur by construction. Verification asserts `!(push && count == DEPTH)`.
- **Pop when empty** is ignored; `res_ready` is don't-care while `res_valid == 0`.
- **Opcodes:** all 16 `sel` values are queued unchanged, including codes the ALU does not implement. Flags are computed from whatever `alu_out` holds.
- **Ordering:** results leave in strict issue order.

## Timing
- **Reset (async assert, any time):**
  - `inflight`, `inflight_sel`, both pointers, `count`, and every storage entry go to 0.
  - As a result, `res_valid=0`, `res_data=0`, `res_sel=0`, `res_zero=1`, `res_neg=0`, `count=0`.
  - `issue_ready=0` while `rst` is high.
- **Reset release:** `issue_ready=1` in the first cycle after `rst` falls.
- **Reset mid-operation:** any in-flight ALU result is discarded. The ALU itself has no reset, and its stale `out` is never captured.
- **Latency:**
  - Issue accepted at edge N, ALU registers the result at N, entry pushed at edge N+1.
  - `res_valid` rises in cycle N+1, so it is visible 2 edges after the issue cycle began.
  - With `res_ready` high, the pop occurs at edge N+2.
- **Throughput:** one result per cycle when `res_ready` is held high. In steady state `count ≤ 1` and `inflight = 1`, so `issue_ready` stays 1 for DEPTH ≥ 3.
- **Backpressure:**
  - With `res_ready=0`, exactly DEPTH issues are accepted.
  - `issue_ready` drops in the cycle where `count + inflight == DEPTH`.
  - It reasserts in the cycle after the first pop edge.
- **Handshakes:**
  - `res_*` are stable while `res_valid && !res_ready`.
  - `issue_ready` never depends combinationally on `issue_valid` or `res_ready`.

## Test plan
- **Reset:** pulse `rst` mid-cycle with `count=2, inflight=1` -> `res_valid` falls immediately, `count=0`, `issue_ready=0` during reset, `issue_ready=1` after release; no entry appears within 3 cycles.
- **Single op:** `sel=0000`, `a=F0F0F0F0`, `b=0F0F0F0F` -> `res_valid` in cycle N+1 with `res_data=0`, `res_zero=1`, `res_neg=0`, `res_sel=0`. Then `sel=0001` on the same operands -> `res_data=FFFFFFFF`, `res_neg=1`, `res_zero=0`.
- **Backpressure:** `res_ready=0`, `issue_valid=1` for 8 cycles with `sel` = 0,1,2,0,1,2,0,1 -> exactly 4 accepts (sels 0,1,2,0), `count` reaches 4 and `issue_ready=0`. Raising `res_ready` drains the entries in order, and the 5th issue is accepted the cycle after the first pop.
- **Streaming:** 20 back-to-back XOR ops (`a=i`, `b=i<<4`) with `res_ready=1` -> `issue_ready` never drops, one result per cycle, data equals `i^(i<<4)` in order.
- **Push+pop:** hold `count=2`, issue and pop in the same cycle -> `count` stays 2 and head advances.
- **Wrap-around:** 11 ops with `res_ready` toggling pseudo-randomly -> pointers wrap at least twice, order and flags match the scoreboard, and the no-push-when-full assertion never fires.

Source files
------------

// File: rtl/alu32_result_queue.sv
// alu32_result_queue
//
// Companion to the alu32 stage. It remembers which operations were issued to
// the ALU, grabs each registered ALU result one cycle after issue, tags it with
// its opcode and zero/negative flags, and holds it in a small in-order FIFO.
// The FIFO is drained by a consumer over a valid/ready handshake.
//
// The issue side is throttled by a credit signal (issue_ready), so a result
// can never arrive while the FIFO has no room for it.
//
// Handshakes:
//   issue side   : an operation is accepted on a rising edge where
//                  issue_valid && issue_ready. issue_ready is a function of
//                  registered state only. It never looks at issue_valid or
//                  res_ready.
//   result side  : the head entry is transferred on a rising edge where
//                  res_valid && res_ready. The res_* outputs hold steady while
//                  res_valid && !res_ready. res_ready is ignored while the
//                  FIFO is empty.
//
// Ports:
//   clk          in  : rising-edge clock, shared with alu32
//   rst          in  : asynchronous, active-high reset
//   issue_valid  in  : issuer presents an operation to the ALU this cycle
//   issue_sel    in  : opcode driven to the ALU alongside issue_valid
//   issue_ready  out : credit; the issuer may issue this cycle
//   alu_out      in  : registered ALU result
//   res_valid    out : head FIFO entry is valid
//   res_data     out : head result
//   res_sel      out : opcode of the head result
//   res_zero     out : head result equals zero
//   res_neg      out : sign bit of the head result
//   res_ready    in  : consumer accepts the head entry
//   count        out : FIFO occupancy, 0..DEPTH

module alu32_result_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic [3:0]    issue_sel,
  output logic          issue_ready,
  input  logic [W-1:0]  alu_out,
  output logic          res_valid,
  output logic [W-1:0]  res_data,
  output logic [3:0]    res_sel,
  output logic          res_zero,
  output logic          res_neg,
  input  logic          res_ready,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  // Operation tracking: one ALU op is "in flight" in the cycle after it is
  // accepted. During that cycle alu_out carries the op's result.
  logic       inflight;
  logic [3:0] inflight_sel;

  // FIFO storage and pointers. The pointers carry one extra bit so that
  // full (DEPTH) and empty (0) are distinguishable. The address is the low
  // AW bits, so wrap-around needs no special handling.
  logic [W-1:0] data_mem [DEPTH];
  logic [3:0]   sel_mem  [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          acc;
  logic          push;
  logic          pop;
  logic [CW:0]   committed;

  // Occupancy is the pointer distance. It is exact across wrap because the
  // pointers are one bit wider than the address.
  assign count = CW'(wr_ptr - rd_ptr);

  // Credit: entries already stored plus the result still in flight must
  // leave room for one more. A pop in the same cycle earns no credit. This is
  // conservative, but it keeps issue_ready free of any path from res_ready.
  assign committed   = {1'b0, count} + (CW + 1)'(inflight);
  assign issue_ready = !rst && (committed < DEPTH_C);

  assign acc  = issue_valid && issue_ready;
  assign push = inflight;
  assign pop  = res_valid && res_ready;

  // Show-ahead head. The flags are derived from the stored data, so they
  // always describe exactly what res_data shows. A cleared entry therefore
  // reports zero=1 and neg=0.
  assign res_valid = (count != '0);
  assign res_data  = data_mem[rd_ptr[AW-1:0]];
  assign res_sel   = sel_mem[rd_ptr[AW-1:0]];
  assign res_zero  = (res_data == '0);
  assign res_neg   = res_data[W-1];

  // Issue tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight     <= 1'b0;
      inflight_sel <= 4'h0;
    end else begin
      inflight <= acc;
      if (acc) begin
        inflight_sel <= issue_sel;
      end
    end
  end

  // FIFO pointers. A push and a pop on the same edge advance both pointers,
  // which leaves the occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // FIFO storage. Entries are cleared on reset so that an empty queue
  // presents all-zero data on the head outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        sel_mem[i]  <= 4'h0;
      end
    end else if (push) begin
      data_mem[wr_ptr[AW-1:0]] <= alu_out;
      sel_mem[wr_ptr[AW-1:0]]  <= inflight_sel;
    end
  end

endmodule

// File: tb/tb_alu32_result_queue.sv
module tb_alu32_result_queue;

  localparam int DEPTH = 4;
  localparam int W     = 32;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [3:0]    issue_sel;
  logic          issue_ready;
  logic [W-1:0]  alu_out;
  logic          res_valid;
  logic [W-1:0]  res_data;
  logic [3:0]    res_sel;
  logic          res_zero;
  logic          res_neg;
  logic          res_ready;
  logic [CW-1:0] count;

  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;

  alu32_result_queue #(.DEPTH(DEPTH), .W(W), .CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .issue_valid(issue_valid),
    .issue_sel(issue_sel),
    .issue_ready(issue_ready),
    .alu_out(alu_out),
    .res_valid(res_valid),
    .res_data(res_data),
    .res_sel(res_sel),
    .res_zero(res_zero),
    .res_neg(res_neg),
    .res_ready(res_ready),
    .count(count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks    = 0;
  int failures  = 0;
  int acc_count = 0;
  int pop_count = 0;

  logic [W+3:0] exp_q[$];   // {sel, data}
  logic [W+3:0] exp_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- ALU stand-in ----------------
  function automatic logic [W-1:0] alu_f(input logic [3:0] s, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (s)
      4'h0:    alu_f = a & b;
      4'h1:    alu_f = a | b;
      4'h2:    alu_f = a ^ b;
      4'h3:    alu_f = a + b;
      4'h4:    alu_f = a - b;
      default: alu_f = ~a;
    endcase
  endfunction

  logic         acc_pending = 1'b0;
  logic [W-1:0] alu_next    = '0;
  logic         tb_inflight;

  initial alu_out = 32'hDEADBEEF;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tb_inflight <= 1'b0;
    end else begin
      tb_inflight <= acc_pending;
      if (acc_pending) alu_out <= alu_next;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    #2;
    acc_pending = !rst && issue_valid && issue_ready;
    if (acc_pending) begin
      alu_next = alu_f(issue_sel, op_a, op_b);
      exp_q.push_back({issue_sel, alu_next});
      acc_count++;
    end
    if (!rst && tb_inflight) begin
      checks++;
      if (count == CW'(DEPTH)) begin
        failures++;
        $display("FAIL no_push_when_full: count=%0d with a result in flight", count);
      end
    end
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop: data=%0h with empty expected queue", res_data);
      end else begin
        exp_e = exp_q.pop_front();
        check("pop_data", res_data, exp_e[W-1:0]);
        check("pop_sel",  res_sel,  exp_e[W+3:W]);
        check("pop_zero", res_zero, exp_e[W-1:0] == '0);
        check("pop_neg",  res_neg,  exp_e[W-1]);
        pop_count++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drain();
    issue_valid = 1'b0;
    res_ready   = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!res_valid && !tb_inflight && exp_q.size() == 0) break;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_res_valid", res_valid, 1'b0);
    res_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] data;
    logic         zero;
    logic         neg;
  } vec_t;

  vec_t vecs[6];
  logic [15:0] rr_pat;

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_sel = 4'h0;
    op_a = '0; op_b = '0; res_ready = 1'b0;

    vecs[0] = '{4'h0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{4'h1, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[2] = '{4'h2, 32'h12345678, 32'h0F0F0F0F, 32'h1D3B5977, 1'b0, 1'b0};
    vecs[3] = '{4'h3, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    vecs[4] = '{4'h4, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
    vecs[5] = '{4'hF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_res_valid",   res_valid,   1'b0);
    check("rst_res_data",    res_data,    32'h0);
    check("rst_res_sel",     res_sel,     4'h0);
    check("rst_res_zero",    res_zero,    1'b1);
    check("rst_res_neg",     res_neg,     1'b0);
    check("rst_count",       count,       3'd0);
    check("rst_issue_ready", issue_ready, 1'b0);
    rst = 1'b0;
    #1 check("ready_after_release", issue_ready, 1'b1);

    // single ops, table driven
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      issue_valid = 1'b1; issue_sel = vecs[i].sel; op_a = vecs[i].a; op_b = vecs[i].b;
      @(negedge clk);
      issue_valid = 1'b0;
      check("single_not_yet_valid", res_valid, 1'b0);
      @(negedge clk);
      check("single_valid", res_valid, 1'b1);
      check("single_data",  res_data,  vecs[i].data);
      check("single_sel",   res_sel,   vecs[i].sel);
      check("single_zero",  res_zero,  vecs[i].zero);
      check("single_neg",   res_neg,   vecs[i].neg);
      check("single_count", count,     3'd1);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("single_popped_valid", res_valid, 1'b0);
      check("single_popped_count", count,     3'd0);
    end

    // backpressure
    acc_count = 0;
    res_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      issue_valid = 1'b1;
      issue_sel   = 4'(k % 3);
      op_a        = 32'hA5A50000 + 32'(k);
      op_b        = 32'h0000FF00 + 32'(k);
      @(negedge clk);
    end
    check("bp_accepts",     acc_count,   4);
    check("bp_count_full",  count,       3'd4);
    check("bp_issue_ready", issue_ready, 1'b0);
    check("bp_head_sel",    res_sel,     4'h0);
    issue_sel = 4'h3; op_a = 32'h11111111; op_b = 32'h22222222;
    res_ready = 1'b1;
    check("bp_ready_before_pop", issue_ready, 1'b0);
    @(negedge clk);
    check("bp_ready_after_pop", issue_ready, 1'b1);
    check("bp_count_after_pop", count,       3'd3);
    @(negedge clk);
    check("bp_fifth_accepted", acc_count, 5);
    drain();

    // streaming XOR
    res_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      issue_valid = 1'b1; issue_sel = 4'h2;
      op_a = 32'(i); op_b = 32'(i) << 4;
      @(negedge clk);
      check("stream_issue_ready", issue_ready, 1'b1);
      if (i >= 1) begin
        check("stream_valid", res_valid, 1'b1);
        check("stream_data",  res_data,  32'(i - 1) ^ (32'(i - 1) << 4));
      end
    end
    drain();

    // push and pop on the same edge at count=2
    res_ready = 1'b0;
    issue_valid = 1'b1; issue_sel = 4'h3; op_a = 32'd1;   op_b = 32'd2;
    @(negedge clk);
    op_a = 32'd10; op_b = 32'd20;
    @(negedge clk);
    issue_valid = 1'b0;
    @(negedge clk);
    check("pp_count_before", count,    3'd2);
    check("pp_head_before",  res_data, 32'd3);
    issue_valid = 1'b1; op_a = 32'd100; op_b = 32'd200;
    @(negedge clk);
    issue_valid = 1'b0; res_ready = 1'b1;
    check("pp_count_inflight", count, 3'd2);
    @(negedge clk);
    res_ready = 1'b0;
    check("pp_count_after", count,    3'd2);
    check("pp_head_after",  res_data, 32'd30);
    drain();

    // reset in the middle of operation: count=2, one result in flight
    res_ready = 1'b0;
    issue_valid = 1'b1; issue_sel = 4'h1; op_a = 32'h1; op_b = 32'h2;
    @(negedge clk);
    op_a = 32'h4;
    @(negedge clk);
    op_a = 32'h8;
    @(negedge clk);
    issue_valid = 1'b0;
    check("mr_count_before", count, 3'd2);
    #3 rst = 1'b1;
    exp_q.delete();
    #1;
    check("mr_res_valid", res_valid,   1'b0);
    check("mr_count",     count,       3'd0);
    check("mr_ready_low", issue_ready, 1'b0);
    check("mr_res_zero",  res_zero,    1'b1);
    @(negedge clk);
    check("mr_ready_still_low", issue_ready, 1'b0);
    rst = 1'b0;
    #1 check("mr_ready_release", issue_ready, 1'b1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("mr_no_entry_valid", res_valid, 1'b0);
      check("mr_no_entry_count", count,     3'd0);
    end

    // wrap-around with irregular consumer
    rr_pat = 16'b1011_0010_1101_0110;
    acc_count = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (acc_count >= 11) break;
      issue_valid = 1'b1;
      issue_sel   = 4'(acc_count);
      op_a        = {8'(acc_count), 24'h0} ^ 32'hF000000F;
      op_b        = 32'(acc_count);
      res_ready   = rr_pat[cyc % 16];
      @(negedge clk);
    end
    issue_valid = 1'b0;
    check("wrap_accepts", acc_count, 11);
    drain();

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation did not complete within bound");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
